// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants and the display arbiter state
// encoding. Segment bytes are active-high {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Arbiter ownership phases: nobody owns, an owner is shown, dark gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } arb_state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to seven-segment pattern map.
// Usable by any block that drives a seven-segment digit.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    // Translate one nibble into its lit-segment pattern.
    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: hands the shared multiplexed seven-segment display to
// one requester at a time, enforces a minimum hold time before preemption and
// a one-slot dark gap between owners, and scans the owner's enabled digits
// onto the segment / digit-select pins.
// Build option SEG_ROUND_ROBIN_EN: rotating priority starting after the most
// recent owner; any other pending requester preempts once the hold expires.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*NUM_DIGITS*4-1:0] digits,
    input  logic [NUM_REQ*NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic [7:0]                      seg_out,
    output logic [NUM_DIGITS-1:0]           digit_sel
);

    localparam int REQ_W  = (NUM_REQ     > 1) ? $clog2(NUM_REQ)     : 1;
    localparam int DIG_W  = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int SCAN_W = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    arb_state_e             state_q,     state_d;
    logic [REQ_W-1:0]       owner_q,     owner_d;
    logic [NUM_REQ-1:0]     grant_q,     grant_d;
    logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
    logic [SCAN_W-1:0]      scan_cnt_q,  scan_cnt_d;
    logic [DIG_W-1:0]       digit_idx_q, digit_idx_d;
    logic [7:0]             seg_q,       seg_d;
    logic [NUM_DIGITS-1:0]  digit_sel_q, digit_sel_d;
    logic                   busy_q,      busy_d;
`ifdef SEG_ROUND_ROBIN_EN
    logic [REQ_W-1:0]       last_owner_q;
`endif

    logic                   win_valid_s;
    logic [REQ_W-1:0]       win_idx_s;
    logic                   scan_tick_s;
    logic                   hold_expired_s;
    logic                   release_s;
    logic                   preempt_s;
    logic [3:0]             owner_hex_s;
    logic                   owner_en_s;
    logic [7:0]             dec_seg_s;

    assign scan_tick_s    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign hold_expired_s = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
    // The owner is the only set bit of grant_q while in GRANT.
    assign release_s      = ~|(req & grant_q);

`ifdef SEG_ROUND_ROBIN_EN
    assign preempt_s = hold_expired_s && (|(req & ~grant_q));
`else
    assign preempt_s = hold_expired_s && win_valid_s && (win_idx_s != owner_q);
`endif

    // Select the requester that wins arbitration on the present req vector.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
`ifdef SEG_ROUND_ROBIN_EN
        // Farthest rotation distance first, so the nearest index after
        // last_owner is the one left standing.
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                win_valid_s = win_valid_s |
                              (req[j] && (j == ((int'(last_owner_q) + k) % NUM_REQ)));
                win_idx_s   = (req[j] && (j == ((int'(last_owner_q) + k) % NUM_REQ)))
                              ? REQ_W'(j) : win_idx_s;
            end
        end
`else
        // Highest index first, so the lowest requesting index is left standing.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            win_valid_s = win_valid_s | req[j];
            win_idx_s   = req[j] ? REQ_W'(j) : win_idx_s;
        end
`endif
    end

    // Ownership FSM next state: grant, release/preempt into the dark gap, rearbitrate.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid_s) begin
                    state_d    = GRANT;
                    owner_d    = win_idx_s;
                    grant_d    = NUM_REQ'(1) << win_idx_s;
                    hold_cnt_d = '0;
                end else begin
                    grant_d    = '0;
                end
            end
            GRANT: begin
                // Release and preemption both end ownership the same way.
                if (release_s || preempt_s) begin
                    state_d    = BLANK;
                    grant_d    = '0;
                end else begin
                    hold_cnt_d = hold_expired_s ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
                end
            end
            BLANK: begin
                if (scan_tick_s && win_valid_s) begin
                    state_d    = GRANT;
                    owner_d    = win_idx_s;
                    grant_d    = NUM_REQ'(1) << win_idx_s;
                    hold_cnt_d = '0;
                end else if (scan_tick_s) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                end else begin
                    state_d    = BLANK;
                    grant_d    = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Free-running slot counter and digit index that advances at each slot end.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_tick_s) begin
            scan_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0
                                                                  : digit_idx_q + DIG_W'(1);
        end else begin
            digit_idx_d = digit_idx_q;
        end
    end

    // Fetch the owner's nibble and enable for the digit shown in the next slot.
    always_comb begin
        owner_hex_s = 4'h0;
        owner_en_s  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                owner_hex_s = owner_hex_s |
                              (((r == int'(owner_q)) && (d == int'(digit_idx_d)))
                               ? digits[(r*NUM_DIGITS + d)*4 +: 4] : 4'h0);
                owner_en_s  = owner_en_s |
                              ((r == int'(owner_q)) && (d == int'(digit_idx_d)) &&
                               digit_en[r*NUM_DIGITS + d]);
            end
        end
    end

    seg_hex_decoder u_hex_decoder (
        .hex_i (owner_hex_s),
        .seg_o (dec_seg_s)
    );

    // Display drive: dark the moment ownership ends, otherwise refresh per slot.
    always_comb begin
        seg_d       = seg_q;
        digit_sel_d = digit_sel_q;
        if (state_d != GRANT) begin
            seg_d       = SEG_BLANK;
            digit_sel_d = '0;
        end else if (scan_tick_s && (state_q == GRANT) && owner_en_s) begin
            // Decimal point is never lit.
            seg_d       = dec_seg_s & 8'h7F;
            digit_sel_d = NUM_DIGITS'(1) << digit_idx_d;
        end else if (scan_tick_s) begin
            seg_d       = SEG_BLANK;
            digit_sel_d = '0;
        end else begin
            seg_d       = seg_q;
            digit_sel_d = digit_sel_q;
        end
    end

    assign busy_d = (state_d != IDLE);

    // State, scanner and registered pin drivers; reset darkens the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            grant_q      <= '0;
            hold_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            seg_q        <= SEG_BLANK;
            digit_sel_q  <= '0;
            busy_q       <= 1'b0;
`ifdef SEG_ROUND_ROBIN_EN
            last_owner_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            hold_cnt_q   <= hold_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            seg_q        <= seg_d;
            digit_sel_q  <= digit_sel_d;
            busy_q       <= busy_d;
`ifdef SEG_ROUND_ROBIN_EN
            if ((state_q != GRANT) && (state_d == GRANT)) begin
                last_owner_q <= win_idx_s;
            end else begin
                last_owner_q <= last_owner_q;
            end
`endif
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign seg_out   = seg_q;
    assign digit_sel = digit_sel_q;

endmodule
